// File: rtl/ecc_decode_sequencer.sv
// SECDED (Hamming 16,11) decode sequencer: walks NUM_WORDS encoded words in shared data memory,
// corrects single-bit errors, flags double-bit errors and writes the results back.
module ecc_decode_sequencer #(
    parameter int unsigned AW        = 8,
    parameter int unsigned SRC_BASE  = 30,
    parameter int unsigned DST_BASE  = 0,
    parameter int unsigned NUM_WORDS = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          busy,
    input  logic          core_req,
    output logic          core_gnt,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    input  logic [7:0]    mem_rd_data
);

    localparam int unsigned IdxW = (AW > 1) ? AW - 1 : 1;
    localparam logic [AW-1:0]   SrcBase = AW'(SRC_BASE);
    localparam logic [AW-1:0]   DstBase = AW'(DST_BASE);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRlo,
        StRhi,
        StCap,
        StWlo,
        StWhi,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [7:0]      lo_q, lo_d;
    logic [15:0]     res_q, res_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_wr_en_q, mem_wr_en_d;
    logic [7:0]      mem_wr_data_q, mem_wr_data_d;
    logic [AW-1:0]   word_off;

    // Result layout: {double, single, 3'b000, data[11:1]}.
    function automatic logic [15:0] decode_word(input logic [15:0] w);
        logic [3:0]  syn;
        logic [15:0] c;
        logic        single;
        logic        double;
        syn = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (w[i]) syn = syn ^ 4'(i);
        end
        c      = w;
        single = ^w;
        double = ~single & (syn != 4'd0);
        if (single) c[syn] = ~c[syn];
        return {double, single, 3'b000, c[15:9], c[7:5], c[3]};
    endfunction

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        lo_d          = lo_q;
        res_d         = res_q;
        mem_addr_d    = '0;
        mem_wr_en_d   = 1'b0;
        mem_wr_data_d = 8'h00;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRlo;
                    idx_d   = '0;
                end
            end
            StRlo: state_d = StRhi;
            StRhi: begin
                lo_d    = mem_rd_data;
                state_d = StCap;
            end
            StCap: begin
                res_d   = decode_word({mem_rd_data, lo_q});
                state_d = StWlo;
            end
            StWlo: state_d = StWhi;
            StWhi: begin
                if (idx_q == IdxLast) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StRlo;
                end
            end
            default: state_d = StIdle;
        endcase

        // Memory outputs are registered, so they are decoded from the upcoming state.
        word_off = AW'({idx_d, 1'b0});
        unique case (state_d)
            StRlo: mem_addr_d = SrcBase + word_off;
            StRhi: mem_addr_d = SrcBase + word_off + AW'(1);
            StWlo: begin
                mem_addr_d    = DstBase + word_off;
                mem_wr_en_d   = 1'b1;
                mem_wr_data_d = res_d[7:0];
            end
            StWhi: begin
                mem_addr_d    = DstBase + word_off + AW'(1);
                mem_wr_en_d   = 1'b1;
                mem_wr_data_d = res_d[15:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            lo_q          <= 8'h00;
            res_q         <= 16'h0000;
            mem_addr_q    <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_data_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            lo_q          <= lo_d;
            res_q         <= res_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    assign done        = (state_q == StDone);
    assign busy        = (state_q != StIdle) && (state_q != StDone);
    assign core_gnt    = core_req & ~busy;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_ecc_decode_sequencer.sv
// Self-checking bench for ecc_decode_sequencer: directed SECDED vectors, encoded random words,
// run latency, core arbitration and a reset abort in the middle of a run.
module tb_ecc_decode_sequencer;

    localparam int unsigned AW  = 8;
    localparam int unsigned SRC = 30;
    localparam int unsigned DST = 0;
    localparam int unsigned NW  = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          done;
    logic          busy;
    logic          core_req;
    logic          core_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;
    logic [7:0]    mem_rd_data;

    logic [7:0]  mem [256];
    logic [15:0] exp_res [NW];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ecc_decode_sequencer #(
        .AW       (AW),
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .NUM_WORDS(NW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .core_req   (core_req),
        .core_gnt   (core_gnt),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    // Synchronous RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        mem_rd_data <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] = mem_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Builds a clean codeword: data in its slots, then parity bits chosen to zero the syndrome.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w;
        logic [3:0]  s;
        w = 16'h0000;
        {w[15:9], w[7:5], w[3]} = d;
        s = 4'd0;
        for (int i = 1; i < 16; i++) if (w[i]) s = s ^ 4'(i);
        w[1] = s[0];
        w[2] = s[1];
        w[4] = s[2];
        w[8] = s[3];
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] w);
        return {w[15:9], w[7:5], w[3]};
    endfunction

    task automatic put_word(input int k, input logic [15:0] w);
        mem[SRC + 2 * k]     = w[7:0];
        mem[SRC + 2 * k + 1] = w[15:8];
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_gnt_busy"}, 32'(core_gnt), 32'd0);
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 32'd75);
        check({tag, "_gnt_done"}, 32'(core_gnt), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_dst(input string tag, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            check($sformatf("%s_w%0d_lo", tag, k), 32'(mem[DST + 2 * k]), 32'(exp_res[k][7:0]));
            check($sformatf("%s_w%0d_hi", tag, k), 32'(mem[DST + 2 * k + 1]), 32'(exp_res[k][15:8]));
        end
    endtask

    initial begin
        logic [10:0] d;
        logic [15:0] w;
        int          p1;
        int          p2;

        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        reset    = 1'b0;
        start    = 1'b0;
        core_req = 1'b1;

        // Reset state
        #12;
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wr_data", 32'(mem_wr_data), 32'd0);
        check("rst_gnt", 32'(core_gnt), 32'd1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        core_req = 1'b0;
        #1 check("idle_gnt_noreq", 32'(core_gnt), 32'd0);
        core_req = 1'b1;

        // Directed words: clean, d2 flipped, p0 flipped, two flips
        mem[30] = 8'h0F; mem[31] = 8'h00; exp_res[0] = 16'h0001;
        mem[32] = 8'h2F; mem[33] = 8'h00; exp_res[1] = 16'h4001;
        mem[34] = 8'h0E; mem[35] = 8'h00; exp_res[2] = 16'h4001;
        mem[36] = 8'h2F; mem[37] = 8'h02; exp_res[3] = 16'h8013;

        // Random encoded words with 0, 1 or 2 distinct flipped bits
        for (int k = 4; k < int'(NW); k++) begin
            d  = 11'($urandom);
            w  = encode(d);
            p1 = int'($urandom_range(15, 0));
            p2 = (p1 + 1 + int'($urandom_range(14, 0))) % 16;
            case (k % 3)
                0: exp_res[k] = {5'b00000, d};
                1: begin
                    w[p1] = ~w[p1];
                    exp_res[k] = {5'b01000, d};
                end
                default: begin
                    w[p1] = ~w[p1];
                    w[p2] = ~w[p2];
                    exp_res[k] = {5'b10000, extract(w)};
                end
            endcase
            put_word(k, w);
        end

        // Full run with core_req held high
        pulse_start();
        wait_done("run1");
        check_dst("run1", NW);
        repeat (3) @(negedge clk);
        check("done_held", 32'(done), 32'd1);

        // Abort in WLO of word 7
        for (int a = 0; a < 2 * int'(NW); a++) mem[DST + a] = 8'hAA;
        pulse_start();
        check("done_drops", 32'(done), 32'd0);
        repeat (38) @(negedge clk);
        check("wlo7_wr_en", 32'(mem_wr_en), 32'd1);
        check("wlo7_addr", 32'(mem_addr), 32'(DST + 14));
        reset = 1'b0;
        #1;
        check("abort_wr_en", 32'(mem_wr_en), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_wr_data", 32'(mem_wr_data), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_gnt", 32'(core_gnt), 32'd1);
        @(negedge clk) reset = 1'b1;
        repeat (4) @(negedge clk);
        check("no_resume_busy", 32'(busy), 32'd0);
        check("no_resume_done", 32'(done), 32'd0);
        check_dst("abort", 7);
        check("abort_w7_lo", 32'(mem[DST + 14]), 32'hAA);
        check("abort_w7_hi", 32'(mem[DST + 15]), 32'hAA);

        // Fresh run after the abort completes every word
        pulse_start();
        wait_done("run2");
        check_dst("run2", NW);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
